// File: rtl/gcd_pkg.sv
// Shared state encoding and latency helper for the binary (Stein) GCD engine.
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      REDUCE,
      DONE
   } gcd_state_e;

   // Worst-case edges from accept to DONE entry for a given operand width.
   function automatic int max_latency(input int width);
      return 4 * width + 2;
   endfunction

endpackage

// File: rtl/gcd_stein_engine_if.sv
// Operand/result valid-ready channels of the GCD engine.
interface gcd_stein_engine_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(4 * WIDTH + 3)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] xin;
   logic [WIDTH-1:0] yin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] gcd_out;
   logic             zero_flg;
   logic [CNT_W-1:0] cycles;

   modport master (
      output in_valid, xin, yin, out_ready,
      input  in_ready, out_valid, gcd_out, zero_flg, cycles
   );

   modport slave (
      input  in_valid, xin, yin, out_ready,
      output in_ready, out_valid, gcd_out, zero_flg, cycles
   );
endinterface

// File: rtl/gcd_stein_step.sv
// One REDUCE iteration of the binary GCD: halve an even operand, else subtract smaller from larger.
module gcd_stein_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   output logic [WIDTH-1:0] o_x,
   output logic [WIDTH-1:0] o_y,
   output logic             o_eq
);

   always_comb begin
      // NOTE: every output gets a default before the branches so no path leaves one unassigned (no latch).
      o_x  = i_x;
      o_y  = i_y;
      o_eq = 1'b0;
      if (!i_x[0]) begin
         o_x = i_x >> 1;
      end else if (!i_y[0]) begin
         o_y = i_y >> 1;
      end else if (i_x == i_y) begin
         o_eq = 1'b1;
      end else if (i_x > i_y) begin
         o_x = i_x - i_y;
      end else begin
         o_y = i_y - i_x;
      end
   end

endmodule

// File: rtl/gcd_stein_engine.sv
// Handshaked binary GCD engine: strips common factors of two, reduces odd pair, restores the shift.
module gcd_stein_engine
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(max_latency(WIDTH) + 1)
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              abort,
   gcd_stein_engine_if.slave bus
);

   localparam int K_W = $clog2(WIDTH);

   gcd_state_e       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_x, w_x_nxt;
   logic [WIDTH-1:0] r_y, w_y_nxt;
   logic [K_W-1:0]   r_k, w_k_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [WIDTH-1:0] r_gcd, w_gcd_nxt;
   logic             r_zero, w_zero_nxt;
   logic [CNT_W-1:0] r_cycles, w_cycles_nxt;
   logic [WIDTH-1:0] w_step_x, w_step_y;
   logic             w_step_eq;

   gcd_stein_step #(.WIDTH(WIDTH)) u_step (
      .i_x  (r_x),
      .i_y  (r_y),
      .o_x  (w_step_x),
      .o_y  (w_step_y),
      .o_eq (w_step_eq)
   );

   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

   always_comb begin
      w_state_nxt  = r_state;
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;
      w_k_nxt      = r_k;
      w_cnt_nxt    = r_cnt;
      w_gcd_nxt    = r_gcd;
      w_zero_nxt   = r_zero;
      w_cycles_nxt = r_cycles;
      unique case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_x_nxt    = bus.xin;
               w_y_nxt    = bus.yin;
               w_k_nxt    = '0;
               w_cnt_nxt  = CNT_W'(1);
               w_zero_nxt = 1'b0;
               if ((bus.xin == '0) || (bus.yin == '0)) begin
                  w_gcd_nxt    = bus.xin | bus.yin;
                  w_zero_nxt   = 1'b1;
                  w_cycles_nxt = CNT_W'(1);
                  w_state_nxt  = DONE;
               end else begin
                  w_state_nxt = SHIFT;
               end
            end
         end
         SHIFT: begin
            w_cnt_nxt = w_cnt_inc;
            if (!r_x[0] && !r_y[0]) begin
               w_x_nxt = r_x >> 1;
               w_y_nxt = r_y >> 1;
               w_k_nxt = r_k + K_W'(1);
            end else begin
               w_state_nxt = REDUCE;
            end
         end
         REDUCE: begin
            w_cnt_nxt = w_cnt_inc;
            w_x_nxt   = w_step_x;
            w_y_nxt   = w_step_y;
            // The reported count is the edges elapsed before this final comparison.
            if (w_step_eq) begin
               w_gcd_nxt    = r_x << r_k;
               w_cycles_nxt = r_cnt;
               w_state_nxt  = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (abort) begin
         w_state_nxt  = IDLE;
         w_x_nxt      = '0;
         w_y_nxt      = '0;
         w_k_nxt      = '0;
         w_cnt_nxt    = '0;
         w_gcd_nxt    = '0;
         w_zero_nxt   = 1'b0;
         w_cycles_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state  <= IDLE;
         r_x      <= '0;
         r_y      <= '0;
         r_k      <= '0;
         r_cnt    <= '0;
         r_gcd    <= '0;
         r_zero   <= 1'b0;
         r_cycles <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge values.
         r_state  <= w_state_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_k      <= w_k_nxt;
         r_cnt    <= w_cnt_nxt;
         r_gcd    <= w_gcd_nxt;
         r_zero   <= w_zero_nxt;
         r_cycles <= w_cycles_nxt;
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.gcd_out   = r_gcd;
   assign bus.zero_flg  = r_zero;
   assign bus.cycles    = r_cycles;

endmodule

// File: doc/gcd_stein_engine.md
# gcd_stein_engine

Parametrised, handshaked greatest-common-divisor engine using the binary (Stein) algorithm, replacing the fixed 4-bit subtract-only GCD datapath/controller pair. It accepts one operand pair per transaction over a valid/ready input channel and returns the GCD, a zero-operand flag and an iteration count over a valid/ready output channel. It sits behind any bus adapter or sequencer that needs an arbitrary-width GCD without a divider.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- CNT_W, $clog2(4*WIDTH+3), width of the cycle-count output
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- abort  in  1  synchronous; returns engine to IDLE from any state, drops result
- in_valid  in  1  operand pair valid
- in_ready  out  1  engine can accept (high only in IDLE)
- xin  in  WIDTH  operand X
- yin  in  WIDTH  operand Y
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  consumer accepts result
- gcd_out  out  WIDTH  GCD(xin, yin)
- zero_flg  out  1  at least one operand was zero
- cycles  out  CNT_W  clock edges from accept edge to DONE entry

## Operation
- States: IDLE, SHIFT, REDUCE, DONE.
- IDLE: in_ready=1. Accept when in_valid&in_ready: load x=xin, y=yin, k=0, cnt=1.
  - Either operand zero: result=x|y, zero_flg=1, go DONE (GCD(0,0)=0).
  - Else go SHIFT.
- SHIFT, one action per cycle, cnt++:
  - both x,y even: x>>=1, y>>=1, k++.
  - else go REDUCE (no data change).
- REDUCE, one action per cycle, cnt++, priority order:
  - x even: x>>=1.
  - else y even: y>>=1.
  - else x==y: result=x<<k, go DONE.
  - else x>y: x=x-y; else y=y-x.
- DONE: out_valid=1; gcd_out, zero_flg, cycles held stable until out_valid&out_ready, then IDLE.
- Arithmetic: subtraction is WIDTH-bit unsigned and never underflows (larger minus smaller). k is at most WIDTH-1, and x<<k fits WIDTH bits. cnt saturates at its maximum (never reached in legal operation).
- abort has priority over all transitions, including a DONE handshake in the same cycle. Outputs revert to their reset values.
- in_valid is ignored outside IDLE. xin/yin need only be stable on the accept edge.

## Timing
- Reset (clr_n low, async): state=IDLE, in_ready=1, out_valid=0, gcd_out=0, zero_flg=0, cycles=0, internal x/y/k/cnt=0. Release is synchronous to the next clk edge.
- Reset mid-transaction discards the operation immediately; no result is ever produced.
- Zero-operand latency: out_valid rises 1 edge after the accept edge (cycles=1).
- Non-zero latency is data-dependent and ≤ 4*WIDTH+2 edges.
- No back-to-back: after the output handshake edge, in_ready is high in the following cycle. Minimum gap between accepts is latency+1.
- Outputs are registered. No combinational path from inputs to outputs except none: in_ready and out_valid decode state only.

## Structure
- Package gcd_pkg: state enum (IDLE, SHIFT, REDUCE, DONE) and a function giving the max-latency bound for a WIDTH.
- Sub-module gcd_stein_step: purely combinational, one REDUCE iteration (x, y in; next x, next y, eq flag out), WIDTH-parametrised. The FSM and registers live in gcd_stein_engine.

## Test plan
- WIDTH=8, xin=12, yin=18 accepted at edge E0 -> out_valid high after E6, gcd_out=6, zero_flg=0, cycles=6. Hold out_ready low 3 cycles: outputs stable, in_ready=0.
- xin=0, yin=45, then 0/0 -> gcd_out=45 then 0, zero_flg=1, cycles=1 each.
- xin=255, yin=1 (worst-case odd path) and xin=128, yin=64 -> gcd 1 and 64, cycles ≤ 34. Random sweep of 10k pairs vs reference model, every latency ≤ 4*WIDTH+2.
- WIDTH=16, xin=40902, yin=24140 -> gcd_out=34. in_valid pulsed while busy: ignored, no second result.
- abort asserted in REDUCE, then in DONE together with out_ready -> next cycle IDLE, out_valid=0, all outputs 0. The next transaction (21, 14) -> 7.
- clr_n pulsed low mid-SHIFT, asynchronously between edges -> outputs go to reset values immediately. The transaction after release (9, 6) -> 3.
